// File: rtl/extender_pipe.sv
// Immediate extender (zero / signed / upper / branch) feeding a 2-entry result FIFO.
// Results appear one cycle after accept; ready/valid on both sides, with synchronous flush.
module extender_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       ext_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       count
);

  if (OUT_W < IMM_W + 2) begin : g_bad_width
    $error("extender_pipe: OUT_W must be at least IMM_W+2");
  end

  typedef enum logic [1:0] {M_ZERO = 2'd0, M_SIGNED = 2'd1, M_UPPER = 2'd2, M_BRANCH = 2'd3} mode_e;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t [1:0] mem;
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         accept, deq;
  logic [OUT_W-1:0] ext_sign, ext_res;

  assign ext_sign = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    ext_res = '0;
    case (mode_e'(ext_mode))
      M_ZERO:   ext_res = {{(OUT_W-IMM_W){1'b0}}, imm};
      M_SIGNED: ext_res = ext_sign;
      M_UPPER:  ext_res = {imm, {(OUT_W-IMM_W){1'b0}}};
      M_BRANCH: ext_res = {ext_sign[OUT_W-3:0], 2'b00};
      default:  ext_res = '0;
    endcase
  end

  // Ready comes only from registered occupancy, so a full FIFO never accepts even while draining.
  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign accept    = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign count     = cnt;
  assign out_data  = out_valid ? mem[rd_ptr].data : '0;
  assign out_tag   = out_valid ? mem[rd_ptr].tag  : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= '{data: ext_res, tag: in_tag};
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({accept, deq})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_extender_pipe.sv
// Directed bench for extender_pipe: queue-based reference model checked every cycle,
// plus literal expectations for the mode sweep, backpressure, flush, async reset and a narrow variant.
module tb_extender_pipe;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] imm;
  logic [1:0]  ext_mode, count;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  // narrow variant
  logic        in_valid2, in_ready2, out_valid2;
  logic [7:0]  imm2;
  logic [1:0]  mode2, count2;
  logic [2:0]  out_tag2;
  logic [15:0] out_data2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  extender_pipe #(.IMM_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .imm(imm),
    .ext_mode(ext_mode), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .count(count));

  extender_pipe #(.IMM_W(8), .OUT_W(16), .TAG_W(3)) dut2 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid2), .in_ready(in_ready2), .imm(imm2),
    .ext_mode(mode2), .in_tag(3'd1), .flush(1'b0), .out_valid(out_valid2),
    .out_ready(1'b1), .out_data(out_data2), .out_tag(out_tag2), .count(count2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from arithmetic on the immediate's numeric value.
  function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] m);
    longint u = longint'(i);
    longint s = (u >= 32768) ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(u);
      2'd1:    return 32'(s);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  typedef struct { logic [31:0] d; logic [4:0] t; } ent_t;
  ent_t q[$];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST || flush) q.delete();
    else begin
      bit acc, dq;
      acc = in_valid && (q.size() < 2);
      dq  = out_ready && (q.size() > 0);
      if (dq) void'(q.pop_front());
      if (acc) q.push_back('{ref_ext(imm, ext_mode), in_tag});
    end
  end

  always @(negedge CLK) begin
    chk("m_out_valid", out_valid, q.size() != 0);
    chk("m_in_ready", in_ready, q.size() < 2);
    chk("m_count", count, q.size());
    chk("m_out_data", out_data, (q.size() != 0) ? q[0].d : 32'd0);
    chk("m_out_tag", out_tag, (q.size() != 0) ? q[0].t : 5'd0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [1:0] m, input logic [4:0] t);
    in_valid = v; imm = i; ext_mode = m; in_tag = t;
  endtask

  logic [15:0] tab_imm [8] = '{16'h7fff, 16'h0000, 16'hffff, 16'h1234, 16'h8000, 16'h00ff, 16'h4001, 16'hc000};
  logic        tab_or  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    nRST = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    in_valid2 = 1'b0; imm2 = 8'h0; mode2 = 2'd0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 2'd0);
    step();
    nRST = 1'b1;

    // mode sweep; later steps overlap accept and dequeue at count=1
    drive(1'b1, 16'h8001, 2'd0, 5'd1); step();
    chk("sweep_zero", out_data, 32'h0000_8001);
    chk("sweep_zero_cnt", count, 2'd1);
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, 2'd1, 5'd2); step();
    chk("sweep_signed", out_data, 32'hffff_8001);
    chk("overlap_cnt", count, 2'd1);
    chk("overlap_tag", out_tag, 5'd2);
    drive(1'b1, 16'h8001, 2'd2, 5'd3); step();
    chk("sweep_upper", out_data, 32'h8001_0000);
    drive(1'b1, 16'h8001, 2'd3, 5'd4); step();
    chk("sweep_branch", out_data, 32'hfffe_0004);
    drive(1'b0, 16'h0, 2'd0, 5'd0); step();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data", out_data, 32'd0);

    // fill and backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'd0, 5'd1); step();
    drive(1'b1, 16'h0022, 2'd0, 5'd2); step();
    chk("full_in_ready", in_ready, 1'b0);
    drive(1'b1, 16'h0033, 2'd0, 5'd3); step();
    chk("full_cnt", count, 2'd2);
    chk("full_head", out_tag, 5'd1);
    out_ready = 1'b1; step();
    chk("full_deq_no_acc", count, 2'd1);
    chk("head_tag2", out_tag, 5'd2);
    step();
    chk("head_tag3", out_tag, 5'd3);
    chk("tag3_data", out_data, 32'h0000_0033);
    drive(1'b0, 16'h0, 2'd0, 5'd0); step();
    chk("empty_again", count, 2'd0);

    // flush while full with a request pending, then at count=1 with an acceptable request
    out_ready = 1'b0;
    drive(1'b1, 16'h0044, 2'd0, 5'd4); step();
    drive(1'b1, 16'h0055, 2'd0, 5'd5); step();
    drive(1'b1, 16'h0066, 2'd0, 5'd6); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("flush_cnt", count, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    drive(1'b1, 16'h0077, 2'd0, 5'd7); step();
    drive(1'b1, 16'h0088, 2'd0, 5'd8); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 16'h0, 2'd0, 5'd0); step();
    chk("flush_drop_cnt", count, 2'd0);
    chk("flush_drop_tag", out_tag, 5'd0);

    // async reset between edges while full
    drive(1'b1, 16'h0099, 2'd1, 5'd9); step();
    drive(1'b1, 16'h00aa, 2'd1, 5'd10); step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_tag", out_tag, 5'd0);
    chk("arst_ready", in_ready, 1'b1);
    step();
    nRST = 1'b1;
    drive(1'b1, 16'hfffe, 2'd3, 5'd11); step();
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    chk("post_rst_cnt", count, 2'd1);
    chk("post_rst_data", out_data, 32'hffff_fff8);
    out_ready = 1'b1; step();

    // mixed directed vectors, checked by the model
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, tab_imm[k], 2'(k), 5'(k + 16));
      out_ready = tab_or[k];
      step();
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0); out_ready = 1'b1;
    step(); step(); step();
    chk("final_empty", count, 2'd0);

    // narrow variant
    in_valid2 = 1'b1; imm2 = 8'h80; mode2 = 2'd1; step();
    chk("v_signed", out_data2, 16'hff80);
    mode2 = 2'd2; step();
    chk("v_upper", out_data2, 16'h8000);
    mode2 = 2'd3; step();
    chk("v_branch", out_data2, 16'hfe00);
    in_valid2 = 1'b0; step();
    chk("v_empty", out_valid2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
